// File: rtl/layer_mem_reader_pkg.sv
// Shared definitions for the layer memory read-back engine: widths,
// layer memory select codes and the sweep state encoding.
package layer_mem_reader_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;

    typedef enum logic [2:0] {
        NONE    = 3'b000,
        L0_MEM0 = 3'b001,
        L0_MEM1 = 3'b010,
        L1_MEM0 = 3'b011,
        L1_MEM1 = 3'b100,
        L2_MEM  = 3'b101
    } csel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/layer_rd_fifo.sv
// Small return buffer holding {last, addr, data} words between the memory
// read port and the output stream; DEPTH must be a power of two.
module layer_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/layer_mem_reader.sv
// Sweeps a contiguous, wrapping address range of one layer memory and returns
// the words as a valid/ready stream tagged with source address and last flag.
module layer_mem_reader #(
    parameter int ADDR_W     = layer_mem_reader_pkg::ADDR_W,
    parameter int DATA_W     = layer_mem_reader_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [2:0]        i_sel,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic [2:0]        csel,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    import layer_mem_reader_pkg::*;

    localparam int FW    = DATA_W + ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    typedef logic [CNT_W:0] credit_t;

    state_e            state;
    state_e            state_next;
    logic [2:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic              inflight_last_q;
    logic              done_q;
    logic              start_ok;
    logic              issue;
    logic              pop;
    logic              last_issue;
    credit_t           credit_used;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign start_ok    = i_start && (state == IDLE);
    assign pop         = o_valid && i_ready;
    assign last_issue  = (remain_q == (ADDR_W + 1)'(1));
    // Buffered words plus the read in flight must leave room for the next return.
    assign credit_used = credit_t'(fifo_count) + credit_t'(inflight_q) - credit_t'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start && (i_count != '0)) state_next = READ;
            READ:    if (issue && last_issue) state_next = DRAIN;
            DRAIN:   if (pop && o_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue    = (state == READ) && (remain_q != '0) &&
                   (credit_used < credit_t'(FIFO_DEPTH)) && (!fifo_full || pop);
        crd      = issue;
        caddr_rd = addr_q;
        o_busy   = (state != IDLE);
        o_done   = done_q;
        csel     = sel_q;
        o_valid  = !fifo_empty;
        {o_last, o_addr, o_data} = fifo_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q           <= NONE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if (start_ok && (i_count != '0)) begin
                sel_q    <= i_sel;
                addr_q   <= i_base;
                remain_q <= i_count;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - (ADDR_W + 1)'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= addr_q;
                inflight_last_q <= last_issue;
            end
            done_q <= (start_ok && (i_count == '0)) || (pop && o_last);
        end
    end

    layer_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .wdata ({inflight_last_q, inflight_addr_q, cdata_rd}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_layer_mem_reader.sv
// Directed bench for layer_mem_reader: a behavioural layer memory answers
// reads one cycle later and every returned word is checked against its address.
module tb_layer_mem_reader;
    import layer_mem_reader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_sel = 3'b000;
    logic [11:0] i_base = '0;
    logic [12:0] i_count = '0;
    logic        o_busy;
    logic        o_done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd = '0;
    logic [2:0]  csel;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [19:0] o_data;
    logic [11:0] o_addr;
    logic        o_last;

    int total = 0;
    int bad = 0;
    int outstanding = 0;
    int credit_viol = 0;

    layer_mem_reader dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_sel    (i_sel),
        .i_base   (i_base),
        .i_count  (i_count),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .csel     (csel),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_addr   (o_addr),
        .o_last   (o_last)
    );

    always #5 clk = ~clk;

    // Memory contents: address + 0x100, offset per layer memory so a wrong select shows up.
    function automatic logic [19:0] mem_val(input logic [2:0] s, input logic [11:0] a);
        return 20'(a) + 20'h100 + (20'(s - 3'd1) << 16);
    endfunction

    always @(posedge clk) begin
        cdata_rd <= crd ? mem_val(csel, caddr_rd) : 20'h0;
    end

    // Words issued but not yet accepted downstream may never exceed the buffer depth.
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(crd) - int'(o_valid && i_ready);
            if (crd && outstanding > 2) credit_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] sel, input logic [11:0] base, input logic [12:0] count);
        i_sel   = sel;
        i_base  = base;
        i_count = count;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Consume a sweep; mode 0 keeps i_ready high, mode 1 drives the 1,0,0,1 pattern.
    task automatic collect(input string tag, input logic [2:0] sel, input logic [11:0] base,
                           input int count, input int mode, input int exp_cycles);
        int got = 0;
        int cyc = 0;
        int dones = 0;
        logic [11:0] ea;
        while (got < count && cyc < count * 4 + 50) begin
            i_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (o_done) dones++;
            if (o_busy && csel !== sel) checkOutput({tag, "_csel"}, 32'(csel), 32'(sel));
            if (o_valid && i_ready) begin
                ea = base + 12'(got);
                checkOutput({tag, "_addr"}, 32'(o_addr), 32'(ea));
                checkOutput({tag, "_data"}, 32'(o_data), 32'(mem_val(sel, ea)));
                checkOutput({tag, "_last"}, 32'(o_last), 32'(got == count - 1));
                got++;
            end
            tick();
            cyc++;
        end
        i_ready = 1'b1;
        checkOutput({tag, "_words"}, 32'(got), 32'(count));
        checkOutput({tag, "_early_done"}, 32'(dones), 32'd0);
        if (exp_cycles != 0) checkOutput({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        checkOutput({tag, "_done"}, 32'(o_done), 32'd1);
        checkOutput({tag, "_busy_drop"}, 32'(o_busy), 32'd0);
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_credit"}, 32'(credit_viol), 32'd0);
    endtask

    initial begin
        int hs;
        tick();
        tick();
        checkOutput("rst_crd", 32'(crd), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_csel", 32'(csel), 32'd0);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_caddr", 32'(caddr_rd), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] basic sweep");
        applyStimulus(L0_MEM0, 12'd0, 13'd8);
        checkOutput("t1_crd_t1", 32'(crd), 32'd1);
        checkOutput("t1_caddr_t1", 32'(caddr_rd), 32'd0);
        checkOutput("t1_busy_t1", 32'(o_busy), 32'd1);
        checkOutput("t1_csel_t1", 32'(csel), 32'(L0_MEM0));
        checkOutput("t1_valid_t1", 32'(o_valid), 32'd0);
        tick();
        checkOutput("t1_crd_t2", 32'(crd), 32'd1);
        checkOutput("t1_caddr_t2", 32'(caddr_rd), 32'd1);
        checkOutput("t1_valid_t2", 32'(o_valid), 32'd0);
        tick();
        checkOutput("t1_valid_t3", 32'(o_valid), 32'd1);
        collect("t1", L0_MEM0, 12'd0, 8, 0, 8);

        $display("[TB] wrap-around");
        applyStimulus(L0_MEM1, 12'd4094, 13'd4);
        collect("t2", L0_MEM1, 12'd4094, 4, 0, 6);

        $display("[TB] backpressure");
        applyStimulus(L0_MEM1, 12'd10, 13'd16);
        collect("t3", L0_MEM1, 12'd10, 16, 1, 0);

        $display("[TB] zero count and busy start");
        applyStimulus(L1_MEM0, 12'd5, 13'd0);
        checkOutput("t4_zero_done", 32'(o_done), 32'd1);
        checkOutput("t4_zero_crd", 32'(crd), 32'd0);
        checkOutput("t4_zero_busy", 32'(o_busy), 32'd0);
        tick();
        checkOutput("t4_zero_done_end", 32'(o_done), 32'd0);
        checkOutput("t4_zero_crd2", 32'(crd), 32'd0);
        applyStimulus(L1_MEM1, 12'd200, 13'd6);
        applyStimulus(L0_MEM0, 12'd0, 13'd3);
        collect("t4", L1_MEM1, 12'd200, 6, 0, 0);

        $display("[TB] full sweep");
        applyStimulus(L2_MEM, 12'd100, 13'd4096);
        collect("t5", L2_MEM, 12'd100, 4096, 0, 4098);

        $display("[TB] reset mid-sweep");
        applyStimulus(L0_MEM1, 12'd300, 13'd20);
        hs = 0;
        for (int c = 0; c < 20 && hs < 5; c++) begin
            if (o_valid && i_ready) hs++;
            if (hs < 5) tick();
        end
        checkOutput("t6_pre_words", 32'(hs), 32'd5);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_crd", 32'(crd), 32'd0);
        checkOutput("t6_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("t6_rst_valid", 32'(o_valid), 32'd0);
        checkOutput("t6_rst_csel", 32'(csel), 32'd0);
        checkOutput("t6_rst_data", 32'(o_data), 32'd0);
        checkOutput("t6_rst_addr", 32'(o_addr), 32'd0);
        checkOutput("t6_rst_done", 32'(o_done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("t6_no_stale", 32'(o_valid), 32'd0);
        checkOutput("t6_no_done", 32'(o_done), 32'd0);
        applyStimulus(L0_MEM0, 12'd50, 13'd5);
        collect("t6", L0_MEM0, 12'd50, 5, 0, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
